mti_adapt_det: RTL and testbench

- Parametrised successor of the MTI threshold path: per-sample zero-clamp, sliding-window mean (N = 2^LOG2N), adaptive door = mean + manual offset, magnitude compare, M-of-N hit detection, raw-sample FIFO.
- Takes samples from the ADC controller (sample_valid = adc_done) and feeds the stream/detect outputs plus the host FIFO read port.
- Adds over the previous generation: true sliding window, warm-up handling, door saturation, mode select, M-of-N, FIFO status/overflow, synchronous clear.

---
 rtl/mti_adapt_det.sv | 182 ++++++++++++++++++
 tb/tb_mti_adapt_det.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mti_adapt_det.sv
// MTI adaptive threshold detector: zero-clamped sliding-window mean, saturating adaptive door,
// M-of-N hit gating, and a raw-sample FIFO for host readout.
module mti_adapt_det #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LOG2N = 3,
  parameter int unsigned AW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            sample_valid,
  input  logic [DW-1:0]   sample_data,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   thresh_hander,
  input  logic [LOG2N:0]  hit_m,
  output logic [DW-1:0]   door,
  output logic            stream,
  output logic            detect,
  output logic            det_valid,
  input  logic            fifo_rden,
  output logic [DW-1:0]   fifo_rddata,
  output logic            fifo_rdvalid,
  output logic            fifo_empty,
  output logic            fifo_full,
  output logic [AW:0]     fifo_count,
  output logic            fifo_overflow
);

  localparam int unsigned N     = 1 << LOG2N;
  localparam int unsigned SW    = DW + LOG2N;
  localparam int unsigned Depth = 1 << AW;

  // Window / detection state
  logic [DW-1:0]    win_q [N];
  logic [SW-1:0]    sum_q, sum_d;
  logic [LOG2N:0]   fill_q;
  logic [N-1:0]     hist_q, hist_d;
  logic [DW-1:0]    door_q, door_d;
  logic             stream_q, stream_d;
  logic             detect_q, detect_d;
  logic             det_valid_q;

  logic [DW-1:0]    mag;
  logic [DW-1:0]    mean;
  logic [DW:0]      door_sum;
  logic             warm;
  logic             hit;
  logic [LOG2N:0]   hit_cnt;
  logic [LOG2N:0]   m_eff;

  // FIFO state
  logic [DW-1:0]    mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [DW-1:0]    rddata_q;
  logic             rdvalid_q;
  logic             overflow_q;
  logic             do_rd, do_wr;

  assign mag  = sample_data[DW-1] ? {1'b0, sample_data[DW-2:0]} : '0;
  assign warm = (fill_q == (LOG2N+1)'(N));
  assign mean = DW'(sum_q >> LOG2N);

  assign door_sum = {1'b0, mean} + {1'b0, thresh_hander};

  always_comb begin
    door_d = thresh_hander;
    if (mode != 2'b00 && warm) begin
      door_d = door_sum[DW] ? '1 : door_sum[DW-1:0];
    end
  end

  // The sample is compared against the door built from earlier samples only.
  assign hit    = (mag > door_q);
  assign hist_d = {hist_q[N-2:0], hit};
  assign sum_d  = sum_q + SW'(mag) - SW'(win_q[N-1]);
  assign m_eff  = (hit_m == '0) ? (LOG2N+1)'(1) : hit_m;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N; i++) begin
      hit_cnt = hit_cnt + (LOG2N+1)'(hist_d[i]);
    end
  end

  assign detect_d = (hit_cnt >= m_eff);
  assign stream_d = (mode == 2'b10) ? (hit & detect_d) : hit;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
      sum_q       <= '0;
      fill_q      <= '0;
      hist_q      <= '0;
      stream_q    <= 1'b0;
      detect_q    <= 1'b0;
      det_valid_q <= 1'b0;
    end else begin
      det_valid_q <= sample_valid;
      if (sample_valid) begin
        win_q[0] <= mag;
        for (int i = 1; i < N; i++) begin
          win_q[i] <= win_q[i-1];
        end
        sum_q    <= sum_d;
        hist_q   <= hist_d;
        stream_q <= stream_d;
        detect_q <= detect_d;
        if (!warm) begin
          fill_q <= fill_q + (LOG2N+1)'(1);
        end
      end
    end
  end

  // Clear loads the manual threshold so the door is meaningful straight away.
  always_ff @(posedge clk) begin
    if (!reset) begin
      door_q <= '0;
    end else if (clear) begin
      door_q <= thresh_hander;
    end else begin
      door_q <= door_d;
    end
  end

  assign fifo_full  = (count_q == (AW+1)'(Depth));
  assign fifo_empty = (count_q == '0);
  assign do_rd      = fifo_rden && !fifo_empty;
  assign do_wr      = sample_valid && (!fifo_full || do_rd);

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && !clear && do_wr) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rddata_q   <= '0;
      rdvalid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rdvalid_q <= do_rd;
      count_q   <= count_d;
      if (do_rd) begin
        rddata_q <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (sample_valid && !do_wr) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign door          = door_q;
  assign stream        = stream_q;
  assign detect        = detect_q;
  assign det_valid     = det_valid_q;
  assign fifo_rddata   = rddata_q;
  assign fifo_rdvalid  = rdvalid_q;
  assign fifo_count    = count_q;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_mti_adapt_det.sv
// Directed bench for mti_adapt_det: vector table for detection paths, hand sequences for
// FIFO, clear and reset behaviour.
module tb_mti_adapt_det;

  localparam int unsigned DW    = 16;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned AW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic            sample_valid;
  logic [DW-1:0]   sample_data;
  logic [1:0]      mode;
  logic [DW-1:0]   thresh_hander;
  logic [LOG2N:0]  hit_m;
  logic [DW-1:0]   door;
  logic            stream;
  logic            detect;
  logic            det_valid;
  logic            fifo_rden;
  logic [DW-1:0]   fifo_rddata;
  logic            fifo_rdvalid;
  logic            fifo_empty;
  logic            fifo_full;
  logic [AW:0]     fifo_count;
  logic            fifo_overflow;

  int checks = 0;
  int errors = 0;

  mti_adapt_det #(.DW(DW), .LOG2N(LOG2N), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .mode          (mode),
    .thresh_hander (thresh_hander),
    .hit_m         (hit_m),
    .door          (door),
    .stream        (stream),
    .detect        (detect),
    .det_valid     (det_valid),
    .fifo_rden     (fifo_rden),
    .fifo_rddata   (fifo_rddata),
    .fifo_rdvalid  (fifo_rdvalid),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [15:0] data;
    logic [1:0]  md;
    logic [15:0] thr;
    logic [3:0]  hm;
    logic        st;
    logic        dt;
    logic [15:0] dr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic clr, input logic [15:0] data, input logic [1:0] md,
                              input logic [15:0] thr, input logic [3:0] hm, input logic st,
                              input logic dt, input logic [15:0] dr);
    vec_t v;
    v.clr = clr; v.data = data; v.md = md; v.thr = thr;
    v.hm = hm; v.st = st; v.dt = dt; v.dr = dr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic one_sample(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample_data = '0;
    mode = 2'b01; thresh_hander = 16'h0040; hit_m = 4'd1; fifo_rden = 1'b0;

    // Warm-up: door stays manual for 7 samples, becomes mean + offset after the 8th
    for (int i = 0; i < 8; i++) add(i == 0, 16'h8100, 2'b01, 16'h0040, 4'd1, 1'b1, 1'b1,
                                    (i == 7) ? 16'h0140 : 16'h0040);
    add(1'b0, 16'h8200, 2'b01, 16'h0040, 4'd1, 1'b1, 1'b1, 16'h0160);
    add(1'b0, 16'h8120, 2'b01, 16'h0040, 4'd1, 1'b0, 1'b1, 16'h0164);
    // Zero-clamp: positive samples contribute nothing
    for (int i = 0; i < 8; i++) add(i == 0, 16'h7FFF, 2'b01, 16'h0040, 4'd1, 1'b0, 1'b0,
                                    16'h0040);
    // Manual mode ignores the warm mean
    for (int i = 0; i < 8; i++) add(i == 0, 16'h8100, 2'b00, 16'h0040, 4'd1, 1'b1, 1'b1,
                                    16'h0040);
    // Saturation on the warm window (mean 0x0100)
    add(1'b0, 16'hFFFF, 2'b01, 16'hFFF0, 4'd1, 1'b0, 1'b1, 16'hFFFF);
    // M-of-N gating, 3 of 8, unwarmed so door = 0x0140
    add(1'b1, 16'h8200, 2'b10, 16'h0140, 4'd3, 1'b0, 1'b0, 16'h0140);
    add(1'b0, 16'h8100, 2'b10, 16'h0140, 4'd3, 1'b0, 1'b0, 16'h0140);
    add(1'b0, 16'h8200, 2'b10, 16'h0140, 4'd3, 1'b0, 1'b0, 16'h0140);
    add(1'b0, 16'h8100, 2'b10, 16'h0140, 4'd3, 1'b0, 1'b0, 16'h0140);
    add(1'b0, 16'h8200, 2'b10, 16'h0140, 4'd3, 1'b1, 1'b1, 16'h0140);
    add(1'b1, 16'h8200, 2'b10, 16'h0140, 4'd0, 1'b1, 1'b1, 16'h0140);
    add(1'b1, 16'h8200, 2'b01, 16'h0140, 4'd9, 1'b1, 1'b0, 16'h0140);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst door", door, 0);
    check("rst stream", stream, 0);
    check("rst detect", detect, 0);
    check("rst det_valid", det_valid, 0);
    check("rst rdvalid", fifo_rdvalid, 0);
    check("rst count", fifo_count, 0);
    check("rst empty", fifo_empty, 1);
    check("rst full", fifo_full, 0);
    check("rst overflow", fifo_overflow, 0);
    reset = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      mode = vecs[k].md; thresh_hander = vecs[k].thr; hit_m = vecs[k].hm;
      clear = vecs[k].clr;
      @(negedge clk);
      clear = 1'b0; sample_valid = 1'b1; sample_data = vecs[k].data;
      @(negedge clk);
      sample_valid = 1'b0;
      check($sformatf("v%0d det_valid", k), det_valid, 1);
      check($sformatf("v%0d stream", k), stream, vecs[k].st);
      check($sformatf("v%0d detect", k), detect, vecs[k].dt);
      @(negedge clk);
      check($sformatf("v%0d det_valid drop", k), det_valid, 0);
      check($sformatf("v%0d door", k), door, vecs[k].dr);
    end

    // FIFO fill, overflow, drain, read on empty
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; sample_data = 16'hA000 + 16'(i);
      @(negedge clk);
      check($sformatf("fifo wr%0d count", i), fifo_count, (i < 4) ? i + 1 : 4);
      check($sformatf("fifo wr%0d overflow", i), fifo_overflow, (i == 4) ? 1 : 0);
    end
    sample_valid = 1'b0;
    check("fifo full", fifo_full, 1);
    for (int i = 0; i < 4; i++) begin
      fifo_rden = 1'b1;
      @(negedge clk);
      fifo_rden = 1'b0;
      check($sformatf("fifo rd%0d rdvalid", i), fifo_rdvalid, 1);
      check($sformatf("fifo rd%0d data", i), fifo_rddata, 16'hA000 + 16'(i));
      check($sformatf("fifo rd%0d count", i), fifo_count, 3 - i);
    end
    check("fifo empty", fifo_empty, 1);
    fifo_rden = 1'b1;
    @(negedge clk);
    fifo_rden = 1'b0;
    check("fifo rd empty rdvalid", fifo_rdvalid, 0);
    check("fifo rd empty count", fifo_count, 0);

    // Simultaneous read/write on full, then on empty
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample_data = 16'hB000 + 16'(i);
      @(negedge clk);
    end
    fifo_rden = 1'b1; sample_data = 16'hB004;
    @(negedge clk);
    sample_valid = 1'b0; fifo_rden = 1'b0;
    check("rw full count", fifo_count, 4);
    check("rw full overflow", fifo_overflow, 0);
    check("rw full data", fifo_rddata, 16'hB000);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    sample_valid = 1'b1; fifo_rden = 1'b1; sample_data = 16'hC000;
    @(negedge clk);
    sample_valid = 1'b0; fifo_rden = 1'b0;
    check("rw empty count", fifo_count, 1);
    check("rw empty rdvalid", fifo_rdvalid, 0);

    // Clear on a warm window with a full FIFO, then warm-up restarts
    mode = 2'b01; thresh_hander = 16'h0040; hit_m = 4'd1;
    for (int i = 0; i < 9; i++) one_sample(16'h8100);
    @(negedge clk);
    check("pre-clear door", door, 16'h0140);
    check("pre-clear overflow", fifo_overflow, 1);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("clear count", fifo_count, 0);
    check("clear overflow", fifo_overflow, 0);
    check("clear door", door, 16'h0040);
    check("clear stream", stream, 0);
    for (int i = 0; i < 8; i++) begin
      one_sample(16'h8100);
      @(negedge clk);
      if (i >= 6) check($sformatf("rewarm door s%0d", i + 1), door, (i == 7) ? 16'h0140 : 16'h0040);
    end

    // Synchronous reset mid-run
    @(negedge clk);
    sample_valid = 1'b1; fifo_rden = 1'b1; sample_data = 16'h8300;
    @(negedge clk);
    sample_valid = 1'b0; fifo_rden = 1'b0;
    check("pre-reset det_valid", det_valid, 1);
    check("pre-reset rdvalid", fifo_rdvalid, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid rst door", door, 0);
    check("mid rst stream", stream, 0);
    check("mid rst detect", detect, 0);
    check("mid rst det_valid", det_valid, 0);
    check("mid rst rddata", fifo_rddata, 0);
    check("mid rst rdvalid", fifo_rdvalid, 0);
    check("mid rst count", fifo_count, 0);
    check("mid rst empty", fifo_empty, 1);
    check("mid rst overflow", fifo_overflow, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
